// File: rtl/shim_trigger_sequencer.sv
// shim_trigger_sequencer
//
// Plays a small program of 32-bit trigger-core command words into the trigger
// core's command FIFO. Software loads the schedule once through the program
// port, then a single start pulse runs it for loop_count passes. loop_count of
// 0 repeats the schedule until an abort arrives. An abort always finishes with
// one CANCEL word being written to the FIFO.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   prog_wr_en/addr/data  program memory write port (accepted only when idle)
//   prog_len          words per pass, sampled at start (1 .. 2^ADDR_W)
//   loop_count        passes to run, sampled at start (0 = until abort)
//   start, abort      control pulses
//   cmd_wr_en/word    FIFO write strobe (combinational) and data
//   cmd_buf_full      FIFO full, stalls the push
//   busy              high whenever the sequencer is not idle
//   done              one-cycle pulse on natural completion
//   aborted           one-cycle pulse when the CANCEL word is written
//   prog_err          sticky error (bad start length or write while busy)
//   cur_addr          address currently being fetched or pushed
//   loops_done        completed passes, saturating
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; program memory writable
// S_READ   | cur_addr presented to the memory, read data arrives next cycle
// S_PUSH   | read data drives cmd_word; written when the FIFO has room
// S_CANCEL | CANCEL word drives cmd_word; written once, then back to idle

module shim_trigger_sequencer #(
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] CANCEL_WORD = 32'hE000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_wr_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [31:0]       loop_count,
  input  logic              start,
  input  logic              abort,
  output logic              cmd_wr_en,
  output logic [31:0]       cmd_word,
  input  logic              cmd_buf_full,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              prog_err,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [31:0]       loops_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_PUSH   = 2'd2,
    S_CANCEL = 2'd3
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;
  logic [ADDR_W:0]   len_q;
  logic [31:0]       remain_q;   // passes still to run, counts down
  logic              inf_q;      // loop_count was 0 at start
  logic              last_word;
  logic              start_bad;

  // Program memory: writes only land while idle, read is registered so the
  // word addressed in S_READ is available in S_PUSH. Holding cur_addr during
  // a FIFO stall keeps rd_q, and therefore cmd_word, stable.
  always_ff @(posedge clk) begin
    if (prog_wr_en && state == S_IDLE) begin
      mem[prog_addr] <= prog_data;
    end
    rd_q <= mem[cur_addr];
  end

  assign last_word = ({1'b0, cur_addr} == (len_q - 1'b1));
  assign start_bad = (prog_len == '0) || (prog_len > LEN_MAX);

  assign busy     = (state != S_IDLE);
  assign cmd_word = (state == S_CANCEL) ? CANCEL_WORD : rd_q;

  // Abort suppresses a same-cycle push so the FIFO never sees a data word
  // after the abort request; only the CANCEL that follows.
  always_comb begin
    cmd_wr_en = 1'b0;
    case (state)
      S_PUSH:   cmd_wr_en = !cmd_buf_full && !abort;
      S_CANCEL: cmd_wr_en = !cmd_buf_full;
      default:  cmd_wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      loops_done <= '0;
      len_q      <= '0;
      remain_q   <= '0;
      inf_q      <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      prog_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;

      if (prog_wr_en && state != S_IDLE) begin
        prog_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (abort) begin
            state <= S_CANCEL;
          end else if (start) begin
            if (start_bad) begin
              prog_err <= 1'b1;
            end else begin
              len_q      <= prog_len;
              remain_q   <= loop_count;
              inf_q      <= (loop_count == 32'd0);
              cur_addr   <= '0;
              loops_done <= '0;
              state      <= S_READ;
            end
          end
        end

        S_READ: begin
          state <= abort ? S_CANCEL : S_PUSH;
        end

        S_PUSH: begin
          if (abort) begin
            state <= S_CANCEL;
          end else if (!cmd_buf_full) begin
            if (!last_word) begin
              cur_addr <= cur_addr + 1'b1;
              state    <= S_READ;
            end else begin
              if (loops_done != 32'hFFFF_FFFF) begin
                loops_done <= loops_done + 32'd1;
              end
              cur_addr <= '0;
              if (inf_q || remain_q > 32'd1) begin
                if (!inf_q) begin
                  remain_q <= remain_q - 32'd1;
                end
                state <= S_READ;
              end else begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
        end

        S_CANCEL: begin
          // abort is deliberately not looked at here: one CANCEL per abort.
          if (!cmd_buf_full) begin
            aborted <= 1'b1;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shim_trigger_sequencer.sv
module tb_shim_trigger_sequencer;

  localparam int ADDR_W = 8;
  localparam logic [31:0] W0 = 32'h2000_0010;
  localparam logic [31:0] W1 = 32'hA000_0000;
  localparam logic [31:0] W2 = 32'h8000_0064;
  localparam logic [31:0] CW = 32'hE000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_wr_en;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic [ADDR_W:0]   prog_len;
  logic [31:0]       loop_count;
  logic              start;
  logic              abort;
  logic              cmd_wr_en;
  logic [31:0]       cmd_word;
  logic              cmd_buf_full;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              prog_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       loops_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] log_w[$];
  int          log_c[$];
  logic [31:0] exp_w[$];

  always #5 clk = ~clk;

  shim_trigger_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .prog_wr_en(prog_wr_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .loop_count(loop_count),
    .start(start), .abort(abort),
    .cmd_wr_en(cmd_wr_en), .cmd_word(cmd_word), .cmd_buf_full(cmd_buf_full),
    .busy(busy), .done(done), .aborted(aborted), .prog_err(prog_err),
    .cur_addr(cur_addr), .loops_done(loops_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO side: a write strobe seen mid-cycle is committed at the next edge.
  always @(negedge clk) begin
    if (cmd_wr_en === 1'b1) begin
      log_w.push_back(cmd_word);
      log_c.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (aborted === 1'b1) abort_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < log_w.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), log_w[i], exp_w[i]);
    end
  endtask

  task automatic do_start(input logic [ADDR_W:0] len, input logic [31:0] loops);
    prog_len = len;
    loop_count = loops;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_aborted(input string tag, input int max);
    int n;
    n = 0;
    while (aborted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_aborted_seen"}, aborted, 1'b1);
  endtask

  task automatic wait_loops(input string tag, input logic [31:0] target, input int max);
    int n;
    n = 0;
    while (loops_done !== target && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_loops_reached"}, loops_done, target);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int d0;
    int a0;
    rst = 1'b1; prog_wr_en = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; loop_count = '0; start = 1'b0; abort = 1'b0;
    cmd_buf_full = 1'b0;
    repeat (3) tick();

    // reset state
    mid();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_prog_err", prog_err, 1'b0);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_loops_done", loops_done, 0);
    chk("rst_cmd_wr_en", cmd_wr_en, 1'b0);
    tick();
    rst = 1'b0;

    // load program
    prog_wr_en = 1'b1;
    prog_addr = 8'd0; prog_data = W0; tick();
    prog_addr = 8'd1; prog_data = W1; tick();
    prog_addr = 8'd2; prog_data = W2; tick();
    prog_wr_en = 1'b0;
    tick();

    // two passes, FIFO never full
    log_w.delete(); log_c.delete();
    d0 = done_cnt;
    do_start(9'd3, 32'd2);
    wait_done("t1", 40);
    tick();
    exp_w = '{W0, W1, W2, W0, W1, W2};
    chk_log("t1");
    for (int i = 1; i < log_c.size(); i++) begin
      chk($sformatf("t1_gap%0d", i), log_c[i] - log_c[i-1], 2);
    end
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_loops_done", loops_done, 2);
    chk("t1_busy_after", busy, 1'b0);

    // FIFO full for 5 cycles on the second word
    log_w.delete(); log_c.delete();
    d0 = done_cnt;
    do_start(9'd3, 32'd2);
    tick();                 // S_PUSH word 0 (written)
    tick();                 // S_READ addr 1
    cmd_buf_full = 1'b1;
    tick();                 // S_PUSH word 1, stalled
    for (int i = 0; i < 5; i++) begin
      mid();
      chk($sformatf("t2_hold_word%0d", i), cmd_word, W1);
      chk($sformatf("t2_hold_wr%0d", i), cmd_wr_en, 1'b0);
      tick();
    end
    cmd_buf_full = 1'b0;
    wait_done("t2", 40);
    tick();
    chk_log("t2");
    chk("t2_done_once", done_cnt - d0, 1);

    // infinite loop, abort in S_PUSH after 10 passes
    log_w.delete(); log_c.delete();
    d0 = done_cnt;
    a0 = abort_cnt;
    do_start(9'd3, 32'd0);
    wait_loops("t3", 32'd10, 200);
    tick();                 // S_PUSH word 0 of pass 11
    log_w.delete(); log_c.delete();
    abort = 1'b1;
    mid();
    chk("t3_push_suppressed", cmd_wr_en, 1'b0);
    tick();
    abort = 1'b0;
    wait_aborted("t3", 10);
    tick();
    exp_w = '{CW};
    chk_log("t3");
    chk("t3_abort_once", abort_cnt - a0, 1);
    chk("t3_loops_done", loops_done, 10);
    chk("t3_no_done", done_cnt - d0, 0);
    chk("t3_busy_after", busy, 1'b0);

    // abort from idle with FIFO full for 3 cycles, second abort ignored
    log_w.delete(); log_c.delete();
    a0 = abort_cnt;
    cmd_buf_full = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mid();
    chk("t4_cancel_word", cmd_word, CW);
    chk("t4_hold_wr0", cmd_wr_en, 1'b0);
    tick();
    abort = 1'b1;
    mid();
    chk("t4_hold_wr1", cmd_wr_en, 1'b0);
    tick();
    abort = 1'b0;
    mid();
    chk("t4_hold_wr2", cmd_wr_en, 1'b0);
    tick();
    cmd_buf_full = 1'b0;
    wait_aborted("t4", 10);
    repeat (4) tick();
    chk_log("t4");
    chk("t4_abort_once", abort_cnt - a0, 1);
    chk("t4_busy_after", busy, 1'b0);

    // bad starts and a write while busy
    log_w.delete(); log_c.delete();
    do_start(9'd0, 32'd1);
    tick();
    chk("t5_len0_err", prog_err, 1'b1);
    chk("t5_len0_busy", busy, 1'b0);
    pulse_rst();
    chk("t5_err_cleared", prog_err, 1'b0);
    do_start(9'd257, 32'd1);
    tick();
    chk("t5_len257_err", prog_err, 1'b1);
    chk("t5_len257_busy", busy, 1'b0);
    repeat (3) tick();
    chk("t5_no_writes", log_w.size(), 0);
    pulse_rst();
    log_w.delete(); log_c.delete();
    do_start(9'd3, 32'd1);
    prog_wr_en = 1'b1; prog_addr = 8'd2; prog_data = 32'hDEAD_BEEF;
    tick();
    prog_wr_en = 1'b0;
    tick();
    chk("t5_busy_wr_err", prog_err, 1'b1);
    wait_done("t5", 40);
    tick();
    exp_w = '{W0, W1, W2};
    chk_log("t5");

    // reset mid-pass with FIFO full
    pulse_rst();
    log_w.delete(); log_c.delete();
    do_start(9'd3, 32'd2);
    wait_loops("t6", 32'd1, 40);
    tick();                 // S_PUSH word 0 of pass 2
    log_w.delete(); log_c.delete();
    cmd_buf_full = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    chk("t6_busy", busy, 1'b0);
    chk("t6_wr_en", cmd_wr_en, 1'b0);
    chk("t6_loops_done", loops_done, 0);
    chk("t6_cur_addr", cur_addr, 0);
    cmd_buf_full = 1'b0;
    repeat (4) tick();
    chk("t6_no_cancel", log_w.size(), 0);
    do_start(9'd3, 32'd1);
    wait_done("t6", 40);
    tick();
    exp_w = '{W0, W1, W2};
    chk_log("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
